// File: rtl/asic_cfg_loader.sv
// ---------------------------------------------------------------------------
// asic_cfg_loader
//
// Serial configuration loader for the ASIC bridge. After reset it waits at
// least N_IDLE cycles, then on a synchronised host go level it latches a
// dynamic word and a static word and shifts them out MSB first: the dynamic
// word with SEL=1, a quiet gap, then the static word with SEL=0. SCLK is
// derived from CLK (CLK_DIV cycles per half-period), so the whole block runs
// in one clock domain.
//
// Ports
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset
//   flag_input  asynchronous host go level (2-flop synchronised internally)
//   din_word    dynamic word, latched when the load starts
//   stat_word   static word, latched when the load starts
//   SEL         1 = dynamic register, 0 = static register
//   MOSI        serial data
//   SCLK        serial clock, idles low
//   BUSY        high while shifting or in the gap
//   DONE        high once the load has finished
//
// Optional feature, macro ASIC_CFG_LOADER_DYN_RELOAD_EN:
//   a 0->1 edge on the synchronised go level while in DONE re-latches
//   din_word and resends only the dynamic word, then returns to DONE.
// ---------------------------------------------------------------------------
module asic_cfg_loader #(
    parameter int DYN_W   = 16,
    parameter int STAT_W  = 88,
    parameter int N_IDLE  = 200,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flag_input,
    input  logic [DYN_W-1:0]  din_word,
    input  logic [STAT_W-1:0] stat_word,
    output logic              SEL,
    output logic              MOSI,
    output logic              SCLK,
    output logic              BUSY,
    output logic              DONE
);

    localparam int IDLE_W = $clog2(N_IDLE + 1);
    localparam int DBIT_W = $clog2(DYN_W + 1);
    localparam int SBIT_W = $clog2(STAT_W + 1);
    localparam int HALF_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(N_IDLE);
    localparam logic [DBIT_W-1:0] DBIT_LAST = DBIT_W'(DYN_W - 1);
    localparam logic [SBIT_W-1:0] SBIT_LAST = SBIT_W'(STAT_W - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DYN,
        S_GAP,
        S_STAT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, flag_sync_q;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic [DBIT_W-1:0]   dyn_bcnt_q, dyn_bcnt_d;
    logic [SBIT_W-1:0]   stat_bcnt_q, stat_bcnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [DYN_W-1:0]    dyn_sr_q, dyn_sr_d;
    logic [STAT_W-1:0]   stat_sr_q, stat_sr_d;
    logic                sel_q, mosi_q, sclk_q, busy_q, done_q;
    logic                sel_d, mosi_d, sclk_d, busy_d, done_d;
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
    logic                flag_prev_q;
    logic                reload_q, reload_d;
`endif

    // NOTE: every flop, shift registers included, is a plain register (not a
    // memory array), so all of them take the asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            flag_sync_q <= 1'b0;
            idle_cnt_q  <= '0;
            half_cnt_q  <= '0;
            dyn_bcnt_q  <= '0;
            stat_bcnt_q <= '0;
            gap_cnt_q   <= '0;
            dyn_sr_q    <= '0;
            stat_sr_q   <= '0;
            sel_q       <= 1'b0;
            mosi_q      <= 1'b0;
            sclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
            flag_prev_q <= 1'b0;
            reload_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge; the synchroniser depends on it.
            state_q     <= state_d;
            sync1_q     <= flag_input;
            flag_sync_q <= sync1_q;
            idle_cnt_q  <= idle_cnt_d;
            half_cnt_q  <= half_cnt_d;
            dyn_bcnt_q  <= dyn_bcnt_d;
            stat_bcnt_q <= stat_bcnt_d;
            gap_cnt_q   <= gap_cnt_d;
            dyn_sr_q    <= dyn_sr_d;
            stat_sr_q   <= stat_sr_d;
            sel_q       <= sel_d;
            mosi_q      <= mosi_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
            flag_prev_q <= flag_sync_q;
            reload_q    <= reload_d;
`endif
        end
    end

    // Next-state logic. Counters return to zero at the end of each phase so
    // every phase starts from a clean count.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        half_cnt_d  = half_cnt_q;
        dyn_bcnt_d  = dyn_bcnt_q;
        stat_bcnt_d = stat_bcnt_q;
        gap_cnt_d   = gap_cnt_q;
        dyn_sr_d    = dyn_sr_q;
        stat_sr_d   = stat_sr_q;
        sclk_d      = 1'b0;
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
        reload_d    = reload_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
                if (idle_cnt_q == IDLE_MAX && flag_sync_q) begin
                    dyn_sr_d  = din_word;
                    stat_sr_d = stat_word;
                    state_d   = S_DYN;
                end
            end
            S_DYN: begin
                sclk_d     = sclk_q;
                half_cnt_d = half_cnt_q + 1'b1;
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    // Falling SCLK: the next bit goes out in the same cycle.
                    if (sclk_q) begin
                        dyn_sr_d   = dyn_sr_q << 1;
                        dyn_bcnt_d = dyn_bcnt_q + 1'b1;
                        if (dyn_bcnt_q == DBIT_LAST) begin
                            dyn_bcnt_d = '0;
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
                            state_d = reload_q ? S_DONE : S_GAP;
`else
                            state_d = S_GAP;
`endif
                        end
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_STAT;
                end
            end
            S_STAT: begin
                sclk_d     = sclk_q;
                half_cnt_d = half_cnt_q + 1'b1;
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    if (sclk_q) begin
                        stat_sr_d   = stat_sr_q << 1;
                        stat_bcnt_d = stat_bcnt_q + 1'b1;
                        if (stat_bcnt_q == SBIT_LAST) begin
                            stat_bcnt_d = '0;
                            state_d     = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
                if (flag_sync_q && !flag_prev_q) begin
                    dyn_sr_d = din_word;
                    reload_d = 1'b1;
                    state_d  = S_DYN;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    always_comb begin
        sel_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_DYN: begin
                sel_d  = 1'b1;
                busy_d = 1'b1;
                mosi_d = dyn_sr_d[DYN_W-1];
            end
            S_GAP:  busy_d = 1'b1;
            S_STAT: begin
                busy_d = 1'b1;
                mosi_d = stat_sr_d[STAT_W-1];
            end
            S_DONE: begin
                sel_d  = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign SEL  = sel_q;
    assign MOSI = mosi_q;
    assign SCLK = sclk_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_asic_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_asic_cfg_loader
//
// Self-checking bench for asic_cfg_loader. A cycle-indexed reference model
// derives the expected SEL/MOSI/SCLK/BUSY/DONE for every cycle of a load from
// the phase lengths alone; the serial stream is also reassembled on SCLK
// rising edges and compared against the expected words. Table-driven loads,
// randomised loads, a mid-shift reset and the DONE behaviour (with or without
// ASIC_CFG_LOADER_DYN_RELOAD_EN) are covered.
// ---------------------------------------------------------------------------
module tb_asic_cfg_loader;

    localparam int DYN_W   = 16;
    localparam int STAT_W  = 88;
    localparam int N_IDLE  = 20;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 8;

    localparam int BIT_T = 2 * CLK_DIV;
    localparam int D_LEN = DYN_W * BIT_T;
    localparam int S_LEN = STAT_W * BIT_T;

    typedef struct packed {
        logic sel;
        logic mosi;
        logic sclk;
        logic busy;
        logic done;
    } out_t;

    typedef struct {
        logic [DYN_W-1:0]  din;
        logic [STAT_W-1:0] stat;
        int                flag_dly;
        logic [DYN_W-1:0]  din_late;
        logic [STAT_W-1:0] stat_late;
        bit                toggle;
        logic [DYN_W-1:0]  exp_dyn;
        logic [STAT_W-1:0] exp_stat;
    } vec_t;

    logic              CLK;
    logic              RST_N;
    logic              flag_input;
    logic [DYN_W-1:0]  din_word;
    logic [STAT_W-1:0] stat_word;
    logic              SEL, MOSI, SCLK, BUSY, DONE;

    int n_pass  = 0;
    int n_total = 0;

    asic_cfg_loader #(
        .DYN_W   (DYN_W),
        .STAT_W  (STAT_W),
        .N_IDLE  (N_IDLE),
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .flag_input (flag_input),
        .din_word   (din_word),
        .stat_word  (stat_word),
        .SEL        (SEL),
        .MOSI       (MOSI),
        .SCLK       (SCLK),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic out_t sample();
        return '{sel: SEL, mosi: MOSI, sclk: SCLK, busy: BUSY, done: DONE};
    endfunction

    // Expected outputs t cycles after the edge on which the load starts.
    function automatic out_t model(input int t, input logic [DYN_W-1:0] din,
                                   input logic [STAT_W-1:0] stat, input bit reload);
        out_t o = '0;
        if (t < D_LEN) begin
            o.sel  = 1'b1;
            o.busy = 1'b1;
            o.mosi = din[DYN_W - 1 - t / BIT_T];
            o.sclk = (t % BIT_T) >= CLK_DIV;
        end else if (!reload && t < D_LEN + GAP_CYC) begin
            o.busy = 1'b1;
        end else if (!reload && t < D_LEN + GAP_CYC + S_LEN) begin
            o.busy = 1'b1;
            o.mosi = stat[STAT_W - 1 - (t - D_LEN - GAP_CYC) / BIT_T];
            o.sclk = ((t - D_LEN - GAP_CYC) % BIT_T) >= CLK_DIV;
        end else begin
            o.sel  = 1'b1;
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Leaves the bench at a falling edge with reset released; the next rising
    // edge is edge 1.
    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1 check("reset_outputs", sample(), '0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Runs one load from its start edge, comparing every cycle against the
    // model and reassembling the serial words. abort_t >= 0 pulls reset low
    // asynchronously at that cycle and returns.
    task automatic run_body(input string tag, input logic [DYN_W-1:0] din,
                            input logic [STAT_W-1:0] stat, input bit reload,
                            input logic [DYN_W-1:0] din_late,
                            input logic [STAT_W-1:0] stat_late,
                            input bit toggle, input int abort_t,
                            output logic [DYN_W-1:0] got_dyn,
                            output logic [STAT_W-1:0] got_stat,
                            output int rises);
        out_t cur;
        logic prev_sclk = 1'b0;
        int   last = (reload ? D_LEN : D_LEN + GAP_CYC + S_LEN) + 3;
        got_dyn  = '0;
        got_stat = '0;
        rises    = 0;
        for (int t = 0; t <= last; t++) begin
            tick();
            cur = sample();
            check($sformatf("%s_t%0d", tag, t), cur, model(t, din, stat, reload));
            if (cur.sclk && !prev_sclk) begin
                rises++;
                if (cur.sel) got_dyn  = {got_dyn[DYN_W-2:0], cur.mosi};
                else         got_stat = {got_stat[STAT_W-2:0], cur.mosi};
            end
            prev_sclk = cur.sclk;
            if (t == 3) begin
                din_word  = din_late;
                stat_word = stat_late;
            end
            if (toggle && t < D_LEN && t % 5 == 0) flag_input = ~flag_input;
            if (toggle && t == D_LEN) flag_input = 1'b1;
            if (t == abort_t) begin
                #2 RST_N = 1'b0;
                #1 check({tag, "_abort_outputs"}, sample(), '0);
                return;
            end
        end
    endtask

    // Reset, idle wait (flag raised after edge flag_dly, or before release if
    // 0), then a full load with end-of-load checks.
    task automatic run_load(input string tag, input logic [DYN_W-1:0] din,
                            input logic [STAT_W-1:0] stat, input int flag_dly,
                            input logic [DYN_W-1:0] din_late,
                            input logic [STAT_W-1:0] stat_late,
                            input bit toggle, input int abort_t,
                            input logic [DYN_W-1:0] exp_dyn,
                            input logic [STAT_W-1:0] exp_stat);
        logic [DYN_W-1:0]  got_dyn;
        logic [STAT_W-1:0] got_stat;
        int rises;
        int quiet = 0;
        int start = (flag_dly + 3 > N_IDLE + 1) ? flag_dly + 3 : N_IDLE + 1;
        din_word   = din;
        stat_word  = stat;
        flag_input = (flag_dly == 0);
        apply_reset();
        for (int e = 1; e < start; e++) begin
            tick();
            if (sample() !== '0) quiet++;
            if (e == flag_dly) flag_input = 1'b1;
        end
        check({tag, "_idle_quiet"}, quiet, 0);
        run_body(tag, din, stat, 1'b0, din_late, stat_late, toggle, abort_t,
                 got_dyn, got_stat, rises);
        if (abort_t < 0) begin
            check({tag, "_dyn_word"}, got_dyn, exp_dyn);
            check({tag, "_stat_word"}, got_stat, exp_stat);
            check({tag, "_sclk_rises"}, rises, DYN_W + STAT_W);
        end
    endtask

    vec_t vecs[4];

    initial begin
        logic [DYN_W-1:0]  rd, rdl, got_dyn;
        logic [STAT_W-1:0] rs, rsl, got_stat;
        int rises;
        int bad;

        RST_N      = 1'b0;
        flag_input = 1'b0;
        din_word   = '0;
        stat_word  = '0;

        vecs[0] = '{16'hABC6, 88'h123456789ABCDEF1234567, 0, 16'hABC6,
                    88'h123456789ABCDEF1234567, 1'b0, 16'hABC6, 88'h123456789ABCDEF1234567};
        vecs[1] = '{16'hABC6, 88'h123456789ABCDEF1234567, 0, 16'h5A5A,
                    88'hFEDCBA9876543210FEDCBA, 1'b1, 16'hABC6, 88'h123456789ABCDEF1234567};
        vecs[2] = '{16'hFFFF, 88'h0, 500, 16'h0000,
                    {STAT_W{1'b1}}, 1'b0, 16'hFFFF, 88'h0};
        vecs[3] = '{16'h0001, {STAT_W{1'b1}}, 7, 16'h8000,
                    88'h0, 1'b1, 16'h0001, {STAT_W{1'b1}}};

        for (int i = 0; i < 4; i++)
            run_load($sformatf("vec%0d", i), vecs[i].din, vecs[i].stat, vecs[i].flag_dly,
                     vecs[i].din_late, vecs[i].stat_late, vecs[i].toggle, -1,
                     vecs[i].exp_dyn, vecs[i].exp_stat);

        for (int i = 0; i < 3; i++) begin
            rd  = DYN_W'($urandom());
            rdl = DYN_W'($urandom());
            rs  = STAT_W'({$urandom(), $urandom(), $urandom()});
            rsl = STAT_W'({$urandom(), $urandom(), $urandom()});
            run_load($sformatf("rnd%0d", i), rd, rs, int'($urandom_range(0, 40)),
                     rdl, rsl, 1'(($urandom() & 1)), -1, rd, rs);
        end

        // Reset while bit 40 of the static word is on the wire, then restart.
        run_load("abort", 16'hABC6, 88'h123456789ABCDEF1234567, 0, 16'hABC6,
                 88'h123456789ABCDEF1234567, 1'b0,
                 D_LEN + GAP_CYC + 40 * BIT_T + CLK_DIV, 16'hABC6, 88'h0);
        run_load("restart", 16'hABC6, 88'h123456789ABCDEF1234567, 0, 16'hABC6,
                 88'h123456789ABCDEF1234567, 1'b0, -1, 16'hABC6,
                 88'h123456789ABCDEF1234567);

        // Go pulse while in DONE.
        din_word   = 16'h00FF;
        flag_input = 1'b0;
        repeat (4) tick();
        flag_input = 1'b1;
        bad = 0;
        repeat (2) begin
            tick();
            if (sample() !== model(1_000_000, '0, '0, 1'b0)) bad++;
        end
        check("done_before_pulse_sync", bad, 0);
`ifdef ASIC_CFG_LOADER_DYN_RELOAD_EN
        run_body("reload", 16'h00FF, '0, 1'b1, 16'h5A5A, '0, 1'b0, -1,
                 got_dyn, got_stat, rises);
        check("reload_dyn_word", got_dyn, 16'h00FF);
        check("reload_sclk_rises", rises, DYN_W);
`else
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (SCLK !== 1'b0 || DONE !== 1'b1 || BUSY !== 1'b0 || SEL !== 1'b1) bad++;
        end
        check("done_ignores_flag", bad, 0);
        got_dyn  = '0;
        got_stat = '0;
        rises    = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
